// File: rtl/wb_conbus_rr.sv
// Shared Wishbone bus: round-robin master arbitration, upper-bit slave decode, error on unmapped/hung slaves.
// Grant one edge after cyc; ack/data routed combinationally; owner keeps the bus until its cyc drops.
module wb_conbus_rr #(
    parameter int NUM_MASTERS = 2,
    parameter int NUM_SLAVES  = 8,
    parameter int ADR_W       = 32,
    parameter int DEC_W       = 4,
    parameter logic [NUM_SLAVES*DEC_W-1:0] SLAVE_ADDRS =
        {4'h7, 4'h6, 4'h5, 4'h4, 4'h8, 4'h3, 4'h2, 4'h0},
    parameter int TIMEOUT     = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_MASTERS*ADR_W-1:0]  m_adr_i,
    input  logic [NUM_MASTERS*32-1:0]     m_dat_i,
    input  logic [NUM_MASTERS*4-1:0]      m_sel_i,
    input  logic [NUM_MASTERS-1:0]        m_we_i,
    input  logic [NUM_MASTERS-1:0]        m_cyc_i,
    input  logic [NUM_MASTERS-1:0]        m_stb_i,
    output logic [31:0]                   m_dat_o,
    output logic [NUM_MASTERS-1:0]        m_ack_o,
    output logic [NUM_MASTERS-1:0]        m_err_o,
    output logic [ADR_W-1:0]              s_adr_o,
    output logic [31:0]                   s_dat_o,
    output logic [3:0]                    s_sel_o,
    output logic                          s_we_o,
    output logic [NUM_SLAVES-1:0]         s_cyc_o,
    output logic [NUM_SLAVES-1:0]         s_stb_o,
    input  logic [NUM_SLAVES*32-1:0]      s_dat_i,
    input  logic [NUM_SLAVES-1:0]         s_ack_i,
    output logic [NUM_MASTERS-1:0]        grant_o,
    output logic                          bus_err_o
);

    localparam int MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    typedef enum logic {IDLE, OWNED} state_e;

    state_e                 state_q;
    logic [MW-1:0]          owner_q, last_q;
    logic [15:0]            wd_q, wd_d;
    logic [NUM_MASTERS-1:0] uerr_q, uerr_d;
    logic                   useen_q;
    logic [ADR_W-1:0]       uadr_q;

    logic                   granted;
    logic [NUM_MASTERS-1:0] grant_vec;
    logic                   o_cyc, o_stb;
    logic [ADR_W-1:0]       o_adr;
    logic [DEC_W-1:0]       tag;
    logic                   hit;
    logic [SW-1:0]          sidx;
    logic                   pick_vld;
    logic [MW-1:0]          pick;
    int                     idx;
    logic                   ack_in, wd_exp, wd_fire, unmap_new;

    assign granted = (state_q == OWNED);
    assign o_cyc   = granted & m_cyc_i[owner_q];
    assign o_stb   = granted & m_stb_i[owner_q];
    assign o_adr   = granted ? m_adr_i[int'(owner_q)*ADR_W +: ADR_W] : '0;
    assign tag     = o_adr[ADR_W-1 -: DEC_W];

    always_comb begin
        grant_vec = '0;
        if (granted) grant_vec[owner_q] = 1'b1;
    end

    // Search from last+1 upward; iterating downward lets the nearest requester win.
    always_comb begin
        pick_vld = 1'b0;
        pick     = '0;
        idx      = 0;
        for (int i = NUM_MASTERS; i >= 1; i--) begin
            idx = int'(last_q) + i;
            if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
            if (m_cyc_i[idx]) begin
                pick_vld = 1'b1;
                pick     = MW'(idx);
            end
        end
    end

    always_comb begin
        hit  = 1'b0;
        sidx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (SLAVE_ADDRS[i*DEC_W +: DEC_W] == tag) begin
                hit  = 1'b1;
                sidx = SW'(i);
            end
        end
    end

    // An ack in the expiring cycle still counts even though the strobe is withdrawn.
    assign ack_in    = o_stb & hit & s_ack_i[sidx];
    assign wd_exp    = o_stb & hit & ((int'(wd_q) + 1) >= TIMEOUT);
    assign wd_fire   = wd_exp & ~ack_in;
    assign unmap_new = o_stb & ~hit & ~(useen_q && (o_adr == uadr_q));

    always_comb begin
        wd_d = wd_q;
        if (!o_stb || !hit || ack_in || wd_fire) wd_d = '0;
        else if (wd_q != 16'hFFFF)               wd_d = wd_q + 16'd1;
        uerr_d = unmap_new ? grant_vec : '0;
    end

    always_comb begin
        s_cyc_o = '0;
        s_stb_o = '0;
        if (hit) begin
            s_cyc_o[sidx] = o_cyc;
            s_stb_o[sidx] = o_stb & ~wd_exp;
        end
    end

    assign m_ack_o   = ack_in ? grant_vec : '0;
    assign m_err_o   = uerr_q | (wd_fire ? grant_vec : '0);
    assign bus_err_o = (|uerr_q) | wd_fire;
    assign m_dat_o   = (granted && hit) ? s_dat_i[int'(sidx)*32 +: 32] : 32'h0;
    assign s_adr_o   = o_adr;
    assign s_dat_o   = granted ? m_dat_i[int'(owner_q)*32 +: 32] : 32'h0;
    assign s_sel_o   = granted ? m_sel_i[int'(owner_q)*4 +: 4] : 4'h0;
    assign s_we_o    = granted & m_we_i[owner_q];
    assign grant_o   = grant_vec;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= MW'(NUM_MASTERS - 1);
            wd_q    <= '0;
            uerr_q  <= '0;
            useen_q <= 1'b0;
            uadr_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_vld) begin
                        state_q <= OWNED;
                        owner_q <= pick;
                    end
                end
                OWNED: begin
                    if (!m_cyc_i[owner_q]) begin
                        state_q <= IDLE;
                        last_q  <= owner_q;
                    end
                end
                default: state_q <= IDLE;
            endcase
            wd_q   <= wd_d;
            uerr_q <= uerr_d;
            // One error per unmapped address until the strobe falls or the address moves.
            if (unmap_new) begin
                useen_q <= 1'b1;
                uadr_q  <= o_adr;
            end else if (!o_stb) begin
                useen_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wb_conbus_rr.sv
module tb_wb_conbus_rr;

    logic         clk;
    logic         rst;
    logic [31:0]  adr0, adr1;
    logic [63:0]  m_adr_i;
    logic [63:0]  m_dat_i;
    logic [7:0]   m_sel_i;
    logic [1:0]   m_we_i, m_cyc_i, m_stb_i;
    logic [31:0]  m_dat_o;
    logic [1:0]   m_ack_o, m_err_o;
    logic [31:0]  s_adr_o, s_dat_o;
    logic [3:0]   s_sel_o;
    logic         s_we_o;
    logic [7:0]   s_cyc_o, s_stb_o;
    logic [255:0] s_dat_i;
    logic [7:0]   s_ack_i;
    logic [1:0]   grant_o;
    logic         bus_err_o;

    int errors = 0;
    int checks = 0;

    assign m_adr_i = {adr1, adr0};

    wb_conbus_rr #(
        .NUM_MASTERS(2), .NUM_SLAVES(8), .ADR_W(32), .DEC_W(4),
        .SLAVE_ADDRS({4'h7, 4'h6, 4'h5, 4'h4, 4'h8, 4'h3, 4'h2, 4'h0}),
        .TIMEOUT(8)
    ) dut (
        .clk(clk), .rst(rst),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i), .m_we_i(m_we_i),
        .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_dat_o(m_dat_o), .m_ack_o(m_ack_o),
        .m_err_o(m_err_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
        .s_we_o(s_we_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_dat_i(s_dat_i),
        .s_ack_i(s_ack_i), .grant_o(grant_o), .bus_err_o(bus_err_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst     = 1'b0;
        adr0    = 32'h0000_0010;
        adr1    = 32'h3000_0004;
        m_dat_i = {32'h1111_2222, 32'h3333_4444};
        m_sel_i = 8'hF3;
        m_we_i  = 2'b11;
        m_cyc_i = 2'b11;
        m_stb_i = 2'b11;
        s_ack_i = 8'h00;
        for (int k = 0; k < 8; k++) s_dat_i[k*32 +: 32] = 32'hA000_0000 + k;
        s_dat_i[2*32 +: 32] = 32'hDEAD_BEEF;

        // Reset held with both masters requesting
        #2;
        chk("rst_s_cyc", s_cyc_o, 8'h00);
        chk("rst_s_stb", s_stb_o, 8'h00);
        chk("rst_m_ack", m_ack_o, 2'b00);
        chk("rst_m_err", m_err_o, 2'b00);
        chk("rst_grant", grant_o, 2'b00);
        chk("rst_bus_err", bus_err_o, 1'b0);
        chk("rst_s_we", s_we_o, 1'b0);
        chk("rst_m_dat", m_dat_o, 32'h0);
        step();
        step();
        chk("rst_grant_held", grant_o, 2'b00);

        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rel_grant_before_edge", grant_o, 2'b00);
        step();
        chk("rr_grant0", grant_o, 2'b01);
        chk("rr_s_stb0", s_stb_o, 8'h01);
        chk("rr_s_adr0", s_adr_o, 32'h0000_0010);
        chk("rr_s_dat0", s_dat_o, 32'h3333_4444);
        chk("rr_s_sel0", s_sel_o, 4'h3);
        chk("rr_s_we0", s_we_o, 1'b1);
        chk("rr_m_dat0", m_dat_o, 32'hA000_0000);
        chk("rr_noack0", m_ack_o, 2'b00);
        s_ack_i = 8'h01;
        #1;
        chk("rr_ack0", m_ack_o, 2'b01);
        step();
        m_cyc_i[0] = 1'b0;
        m_stb_i[0] = 1'b0;
        s_ack_i    = 8'h00;
        #1;
        chk("rr_hold0", grant_o, 2'b01);
        chk("rr_ack0_off", m_ack_o, 2'b00);
        step();
        chk("rr_gap1", grant_o, 2'b00);
        chk("rr_gap1_cyc", s_cyc_o, 8'h00);
        m_cyc_i[0] = 1'b1;
        m_stb_i[0] = 1'b1;
        step();
        chk("rr_grant1", grant_o, 2'b10);
        chk("dec_s_stb", s_stb_o, 8'h04);
        chk("dec_s_cyc", s_cyc_o, 8'h04);
        s_ack_i = 8'h04;
        #1;
        chk("dec_m_dat", m_dat_o, 32'hDEAD_BEEF);
        chk("dec_m_ack", m_ack_o, 2'b10);
        step();
        m_cyc_i[1] = 1'b0;
        m_stb_i[1] = 1'b0;
        s_ack_i    = 8'h00;
        adr0       = 32'hF000_0000;
        step();
        chk("rr_gap2", grant_o, 2'b00);
        m_cyc_i[1] = 1'b1;
        m_stb_i[1] = 1'b1;
        step();
        chk("rr_grant0_again", grant_o, 2'b01);

        // Unmapped access by master0
        chk("unm_s_cyc", s_cyc_o, 8'h00);
        chk("unm_err_first", m_err_o, 2'b00);
        chk("unm_m_dat", m_dat_o, 32'h0);
        step();
        chk("unm_err", m_err_o, 2'b01);
        chk("unm_bus_err", bus_err_o, 1'b1);
        step();
        chk("unm_err_once", m_err_o, 2'b00);
        chk("unm_bus_err_once", bus_err_o, 1'b0);
        m_cyc_i[0] = 1'b0;
        m_stb_i[0] = 1'b0;
        step();
        chk("rr_gap3", grant_o, 2'b00);
        step();
        chk("rr_grant1_again", grant_o, 2'b10);

        // Watchdog: slave 2 never acks, 8th stalled cycle errors
        chk("wd_stb_c1", s_stb_o, 8'h04);
        for (int k = 2; k <= 7; k++) begin
            step();
            chk("wd_stb_stall", s_stb_o, 8'h04);
            chk("wd_noerr_stall", m_err_o, 2'b00);
        end
        step();
        chk("wd_stb_drop", s_stb_o, 8'h00);
        chk("wd_cyc_kept", s_cyc_o, 8'h04);
        chk("wd_err", m_err_o, 2'b10);
        chk("wd_bus_err", bus_err_o, 1'b1);
        step();
        chk("wd_stb_back", s_stb_o, 8'h04);
        chk("wd_err_clr", m_err_o, 2'b00);
        for (int k = 2; k <= 7; k++) step();
        chk("wd2_stb_c7", s_stb_o, 8'h04);
        step();
        s_ack_i = 8'h04;
        #1;
        chk("wd_ack_wins", m_ack_o, 2'b10);
        chk("wd_ack_noerr", m_err_o, 2'b00);
        chk("wd_ack_nobus", bus_err_o, 1'b0);

        // Reset while slave 0 is strobed by master1
        step();
        s_ack_i = 8'h00;
        adr1    = 32'h0000_0020;
        #1;
        chk("mid_s_stb", s_stb_o, 8'h01);
        chk("mid_m_dat", m_dat_o, 32'hA000_0000);
        s_ack_i    = 8'h01;
        m_cyc_i[0] = 1'b1;
        m_stb_i[0] = 1'b1;
        adr0       = 32'h0000_0010;
        #1;
        chk("mid_ack", m_ack_o, 2'b10);
        rst = 1'b0;
        #1;
        chk("mid_rst_stb", s_stb_o, 8'h00);
        chk("mid_rst_grant", grant_o, 2'b00);
        chk("mid_rst_ack", m_ack_o, 2'b00);
        chk("mid_rst_dat", m_dat_o, 32'h0);
        @(negedge clk);
        rst     = 1'b1;
        s_ack_i = 8'h00;
        step();
        chk("post_rst_grant", grant_o, 2'b01);
        chk("post_rst_stb", s_stb_o, 8'h01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
